multi_port_circ_buffer: RTL and testbench



---
 rtl/multi_port_circ_buffer_pkg.sv | 22 ++
 rtl/multi_port_circ_buffer_if.sv | 36 +++
 rtl/multi_port_circ_buffer_ctrl.sv | 62 ++++++
 rtl/multi_port_circ_buffer.sv | 86 ++++++++
 tb/tb_multi_port_circ_buffer.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/multi_port_circ_buffer_pkg.sv
// Shared widths and pointer arithmetic for the multi-port circular buffer.
// Pure declarations: no latency, no flow control.
package circ_buffer_pkg;

    localparam int MEM_SIZE_DEF  = 8;
    localparam int PAR_WRITE_DEF = 4;
    localparam int PAR_READ_DEF  = 1;

    localparam int PTR_W = $clog2(MEM_SIZE_DEF);
    localparam int LVL_W = $clog2(MEM_SIZE_DEF + 1);
    localparam int NUM_W = $clog2(PAR_WRITE_DEF + 1);

    // ptr < mem_size and inc <= mem_size, so one conditional subtract is enough
    function automatic int wrap_add(input int ptr, input int inc, input int mem_size);
        int sum;
        sum = ptr + inc;
        if (sum >= mem_size)
            sum = sum - mem_size;
        return sum;
    endfunction

endpackage

// File: rtl/multi_port_circ_buffer_if.sv
// Producer/consumer bundle for the circular buffer.
// Combinational wires only; ready/valid/full/almost_full carry the backpressure.
interface multi_port_circ_buffer_if #(
    parameter int SIZE      = 16,
    parameter int MEM_SIZE  = 8,
    parameter int PAR_WRITE = 4,
    parameter int PAR_READ  = 1
);
    localparam int NUM_W = $clog2(PAR_WRITE + 1);
    localparam int LVL_W = $clog2(MEM_SIZE + 1);

    logic                      clear;
    logic                      wen;
    logic [NUM_W-1:0]          wnum;
    logic [PAR_WRITE*SIZE-1:0] din;
    logic                      ren;
    logic [PAR_READ*SIZE-1:0]  dout;
    logic                      valid;
    logic                      ready;
    logic                      full;
    logic                      empty;
    logic                      almost_full;
    logic [LVL_W-1:0]          level;
    logic                      overflow;
    logic                      underflow;

    modport master (
        output clear, wen, wnum, din, ren,
        input  dout, valid, ready, full, empty, almost_full, level, overflow, underflow
    );

    modport slave (
        input  clear, wen, wnum, din, ren,
        output dout, valid, ready, full, empty, almost_full, level, overflow, underflow
    );
endinterface

// File: rtl/multi_port_circ_buffer_ctrl.sv
// Pointer/level bookkeeping and accept/reject decisions for the circular buffer.
// Updates one edge after the request; rejected requests only set the sticky flags.
module circ_buffer_ctrl
    import circ_buffer_pkg::*;
#(
    parameter int MEM_SIZE  = 8,
    parameter int PAR_WRITE = 4,
    parameter int PAR_READ  = 1,
    parameter int PTR_W     = 3,
    parameter int LVL_W     = 4,
    parameter int NUM_W     = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             wen,
    input  logic [NUM_W-1:0] wnum,
    input  logic             ren,
    output logic [PTR_W-1:0] wptr,
    output logic [PTR_W-1:0] rptr,
    output logic [LVL_W-1:0] level,
    output logic             overflow,
    output logic             underflow,
    output logic             wr_acc,
    output logic             rd_acc
);

    logic wnum_ok;
    int   free_slots;
    int   level_nxt;

    // Decisions use the pre-edge level only: a same-cycle read frees nothing
    // for the write, and a same-cycle write supplies nothing to the read.
    always_comb begin
        free_slots = MEM_SIZE - int'(level);
        wnum_ok    = (wnum != '0) && (int'(wnum) <= PAR_WRITE);
        wr_acc     = wen && !clear && wnum_ok && (free_slots >= int'(wnum));
        rd_acc     = ren && !clear && (int'(level) >= PAR_READ);
        level_nxt  = int'(level) + (wr_acc ? int'(wnum) : 0) - (rd_acc ? PAR_READ : 0);
    end

    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            wptr      <= '0;
            rptr      <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc)
                wptr <= PTR_W'(wrap_add(int'(wptr), int'(wnum), MEM_SIZE));
            if (rd_acc)
                rptr <= PTR_W'(wrap_add(int'(rptr), PAR_READ, MEM_SIZE));
            level <= LVL_W'(level_nxt);
            if (wen && !wr_acc)
                overflow <= 1'b1;
            if (ren && !rd_acc)
                underflow <= 1'b1;
        end
    end

endmodule

// File: rtl/multi_port_circ_buffer.sv
// Circular buffer: 1..PAR_WRITE words in, PAR_READ words out per cycle.
// Zero read latency (dout follows rptr); writes visible the cycle after their edge.
// Backpressure via ready/full/almost_full; over-asks are dropped and flagged sticky.
module multi_port_circ_buffer
    import circ_buffer_pkg::*;
#(
    parameter int SIZE      = 16,
    parameter int MEM_SIZE  = 8,
    parameter int PAR_WRITE = 4,
    parameter int PAR_READ  = 1,
    parameter int AF_LEVEL  = MEM_SIZE - PAR_WRITE
) (
    input  logic                    clk,
    input  logic                    rstn,
    multi_port_circ_buffer_if.slave bus
);

    localparam int PTR_W_L = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam int LVL_W_L = $clog2(MEM_SIZE + 1);
    localparam int NUM_W_L = $clog2(PAR_WRITE + 1);

    logic [PTR_W_L-1:0] wptr;
    logic [PTR_W_L-1:0] rptr;
    logic [LVL_W_L-1:0] level;
    logic               wr_acc;
    logic               rd_acc;

    logic [SIZE-1:0]    mem   [MEM_SIZE];
    logic [PTR_W_L-1:0] waddr [PAR_WRITE];
    logic [PTR_W_L-1:0] raddr [PAR_READ];

    circ_buffer_ctrl #(
        .MEM_SIZE  (MEM_SIZE),
        .PAR_WRITE (PAR_WRITE),
        .PAR_READ  (PAR_READ),
        .PTR_W     (PTR_W_L),
        .LVL_W     (LVL_W_L),
        .NUM_W     (NUM_W_L)
    ) u_ctrl (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (bus.clear),
        .wen       (bus.wen),
        .wnum      (bus.wnum),
        .ren       (bus.ren),
        .wptr      (wptr),
        .rptr      (rptr),
        .level     (level),
        .overflow  (bus.overflow),
        .underflow (bus.underflow),
        .wr_acc    (wr_acc),
        .rd_acc    (rd_acc)
    );

    // Per-lane addresses; lanes that cross the end wrap back to the start
    always_comb begin
        for (int i = 0; i < PAR_WRITE; i++)
            waddr[i] = PTR_W_L'(wrap_add(int'(wptr), i, MEM_SIZE));
        for (int j = 0; j < PAR_READ; j++)
            raddr[j] = PTR_W_L'(wrap_add(int'(rptr), j, MEM_SIZE));
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < PAR_WRITE; i++) begin
            if (wr_acc && (i < int'(bus.wnum)))
                mem[waddr[i]] <= bus.din[i*SIZE +: SIZE];
        end
    end

    assign bus.level       = level;
    assign bus.valid       = int'(level) >= PAR_READ;
    assign bus.ready       = (MEM_SIZE - int'(level)) >= PAR_WRITE;
    assign bus.full        = int'(level) == MEM_SIZE;
    assign bus.empty       = level == '0;
    assign bus.almost_full = int'(level) >= AF_LEVEL;

    // Memory is never reset, so hide stale contents until data is present
    always_comb begin
        bus.dout = '0;
        if (bus.valid) begin
            for (int j = 0; j < PAR_READ; j++)
                bus.dout[j*SIZE +: SIZE] = mem[raddr[j]];
        end
    end

endmodule

// File: tb/tb_multi_port_circ_buffer.sv
// Directed bench for multi_port_circ_buffer (SIZE=16, MEM_SIZE=8, PAR_WRITE=4, PAR_READ=1).
module tb_multi_port_circ_buffer;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    multi_port_circ_buffer_if #(.SIZE(16), .MEM_SIZE(8), .PAR_WRITE(4), .PAR_READ(1)) bus ();

    multi_port_circ_buffer #(
        .SIZE(16), .MEM_SIZE(8), .PAR_WRITE(4), .PAR_READ(1), .AF_LEVEL(4)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.clear = 1'b0;
        bus.wen   = 1'b0;
        bus.ren   = 1'b0;
        bus.wnum  = '0;
        bus.din   = '0;
    endtask

    task automatic write(input logic [2:0] n, input logic [63:0] d);
        bus.wen  = 1'b1;
        bus.wnum = n;
        bus.din  = d;
        tick();
        idle();
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", bus.full); end
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.valid); end
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.ready); end
        checks++; if (bus.almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got=%b exp=0", bus.almost_full); end
        checks++; if (bus.level !== 4'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", bus.level); end
        checks++; if (bus.dout !== 16'd0) begin errors++; $display("FAIL reset_dout got=%0d exp=0", bus.dout); end
        checks++; if ({bus.overflow, bus.underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {bus.overflow, bus.underflow}); end
    endtask

    task automatic test_basic();
        logic [15:0] exp [4] = '{16'd5, 16'd1, 16'd8, 16'd12};
        write(3'd4, {16'd12, 16'd8, 16'd1, 16'd5});
        checks++; if (bus.level !== 4'd4) begin errors++; $display("FAIL basic_level got=%0d exp=4", bus.level); end
        checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", bus.valid); end
        checks++; if (bus.almost_full !== 1'b1) begin errors++; $display("FAIL basic_af got=%b exp=1", bus.almost_full); end
        bus.ren = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (bus.dout !== exp[k]) begin errors++; $display("FAIL basic_dout[%0d] got=%0d exp=%0d", k, bus.dout, exp[k]); end
            tick();
        end
        idle();
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL basic_empty got=%b exp=1", bus.empty); end
        checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL basic_underflow got=%b exp=0", bus.underflow); end
    endtask

    task automatic test_full_overflow();
        logic [15:0] exp [4] = '{16'd170, 16'd150, 16'd130, 16'd120};
        write(3'd4, {16'd120, 16'd130, 16'd150, 16'd170});
        write(3'd4, {16'd120, 16'd130, 16'd150, 16'd170});
        checks++; if (bus.level !== 4'd8) begin errors++; $display("FAIL full_level got=%0d exp=8", bus.level); end
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL full_full got=%b exp=1", bus.full); end
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", bus.ready); end
        write(3'd4, {16'd1, 16'd2, 16'd3, 16'd4});
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL full_overflow got=%b exp=1", bus.overflow); end
        checks++; if (bus.level !== 4'd8) begin errors++; $display("FAIL full_level_hold got=%0d exp=8", bus.level); end
        bus.ren = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++; if (bus.dout !== exp[k % 4]) begin errors++; $display("FAIL full_dout[%0d] got=%0d exp=%0d", k, bus.dout, exp[k % 4]); end
            tick();
        end
        idle();
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL full_drained got=%b exp=1", bus.empty); end
        do_clear();
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL full_clear_ovf got=%b exp=0", bus.overflow); end
    endtask

    task automatic test_wrap();
        logic [15:0] exp [4] = '{16'd6, 16'd5, 16'd6, 16'd7};
        write(3'd4, {16'd4, 16'd3, 16'd2, 16'd1});
        write(3'd2, {16'd0, 16'd0, 16'd6, 16'd5});
        bus.ren = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++; if (bus.dout !== 16'(k + 1)) begin errors++; $display("FAIL wrap_pre[%0d] got=%0d exp=%0d", k, bus.dout, k + 1); end
            tick();
        end
        idle();
        write(3'd3, {16'hdead, 16'd7, 16'd6, 16'd5});
        checks++; if (bus.level !== 4'd4) begin errors++; $display("FAIL wrap_level got=%0d exp=4", bus.level); end
        bus.ren = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (bus.dout !== exp[k]) begin errors++; $display("FAIL wrap_dout[%0d] got=%0d exp=%0d", k, bus.dout, exp[k]); end
            tick();
        end
        idle();
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got=%b exp=1", bus.empty); end
    endtask

    task automatic test_simultaneous();
        do_clear();
        write(3'd4, {16'd14, 16'd13, 16'd12, 16'd11});
        write(3'd4, {16'd18, 16'd17, 16'd16, 16'd15});
        bus.wen = 1'b1; bus.wnum = 3'd1; bus.din = 64'd99; bus.ren = 1'b1;
        tick();
        idle();
        checks++; if (bus.level !== 4'd7) begin errors++; $display("FAIL simul_full_level got=%0d exp=7", bus.level); end
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL simul_full_ovf got=%b exp=1", bus.overflow); end
        checks++; if (bus.dout !== 16'd12) begin errors++; $display("FAIL simul_full_dout got=%0d exp=12", bus.dout); end
        do_clear();
        bus.wen = 1'b1; bus.wnum = 3'd1; bus.din = 64'd42; bus.ren = 1'b1;
        tick();
        idle();
        checks++; if (bus.level !== 4'd1) begin errors++; $display("FAIL simul_empty_level got=%0d exp=1", bus.level); end
        checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL simul_empty_udf got=%b exp=1", bus.underflow); end
        checks++; if (bus.dout !== 16'd42) begin errors++; $display("FAIL simul_empty_dout got=%0d exp=42", bus.dout); end
        do_clear();
    endtask

    task automatic test_partial();
        write(3'd2, {16'haaaa, 16'hbbbb, 16'd9, 16'd4});
        checks++; if (bus.level !== 4'd2) begin errors++; $display("FAIL part_level got=%0d exp=2", bus.level); end
        checks++; if (bus.dout !== 16'd4) begin errors++; $display("FAIL part_dout0 got=%0d exp=4", bus.dout); end
        bus.ren = 1'b1;
        tick();
        idle();
        checks++; if (bus.dout !== 16'd9) begin errors++; $display("FAIL part_dout1 got=%0d exp=9", bus.dout); end
        write(3'd0, {16'd1, 16'd2, 16'd3, 16'd4});
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL part_wnum0_ovf got=%b exp=1", bus.overflow); end
        checks++; if (bus.level !== 4'd1) begin errors++; $display("FAIL part_wnum0_level got=%0d exp=1", bus.level); end
        do_clear();
        write(3'd5, {16'd1, 16'd2, 16'd3, 16'd4});
        checks++; if ({bus.overflow, bus.level} !== 5'b1_0000) begin errors++; $display("FAIL part_wnum5 got=%b exp=10000", {bus.overflow, bus.level}); end
        do_clear();
    endtask

    task automatic test_clear();
        write(3'd4, {16'd4, 16'd3, 16'd2, 16'd1});
        write(3'd1, 64'd5);
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL clr_ready5 got=%b exp=0", bus.ready); end
        write(3'd4, {16'd9, 16'd9, 16'd9, 16'd9});
        checks++; if ({bus.overflow, bus.level} !== 5'b1_0101) begin errors++; $display("FAIL clr_pre got=%b exp=10101", {bus.overflow, bus.level}); end
        bus.clear = 1'b1; bus.wen = 1'b1; bus.wnum = 3'd1; bus.din = 64'd77;
        tick();
        idle();
        checks++; if (bus.level !== 4'd0) begin errors++; $display("FAIL clr_level got=%0d exp=0", bus.level); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL clr_empty got=%b exp=1", bus.empty); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL clr_ovf got=%b exp=0", bus.overflow); end
        write(3'd4, {16'd4, 16'd3, 16'd2, 16'd1});
        write(3'd0, 64'd0);
        rstn = 1'b0; bus.clear = 1'b1; bus.wen = 1'b1; bus.wnum = 3'd2; bus.din = 64'd3;
        tick();
        rstn = 1'b1;
        idle();
        checks++; if ({bus.overflow, bus.empty, bus.level} !== 6'b0_1_0000) begin errors++; $display("FAIL rst_mid got=%b exp=010000", {bus.overflow, bus.empty, bus.level}); end
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b exp=1", bus.ready); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_overflow();
        test_wrap();
        test_simultaneous();
        test_partial();
        test_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
